// File: rtl/imem_access_arbiter_if.sv
// Bundle of fetch, loader and RAM-side signals around imem_access_arbiter.
// IMEM_ADDR_CHECK_EN adds the fetch_err / ld_err pulses.
interface imem_access_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_stall;
  logic              ld_req;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef IMEM_ADDR_CHECK_EN
  logic              fetch_err;
  logic              ld_err;
`endif

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_data, cpu_stall,
    output ld_gnt, ld_valid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ADDR_CHECK_EN
    , output fetch_err, ld_err
`endif
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_data, cpu_stall,
    input  ld_gnt, ld_valid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ADDR_CHECK_EN
    , input fetch_err, ld_err
`endif
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Arbitrates a single-port instruction RAM between CPU fetch and a program loader.
// Define IMEM_ADDR_CHECK_EN to reject misaligned/out-of-range addresses with err pulses.
module imem_access_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MAX_LD_BURST = 4
) (
  input logic                  clk,
  input logic                  reset,
  imem_access_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LD_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_LD_BURST);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD} state_t;
  typedef enum logic [1:0] {R_NONE, R_FETCH, R_LOAD_RD, R_LOAD_WR} resp_t;

  state_t           r_state, w_next_state;
  resp_t            w_resp_owner;
  logic [CNT_W-1:0] r_burst_cnt, w_next_burst_cnt;
  logic             r_ld_wr;
  logic             r_err;
  logic             w_fetch_gnt, w_ld_gnt, w_accept, w_addr_ok;
  logic [31:0]      w_sel_addr;

  assign w_sel_addr = w_ld_gnt ? bus.ld_addr : bus.fetch_addr;
  assign w_accept   = w_fetch_gnt | w_ld_gnt;

`ifdef IMEM_ADDR_CHECK_EN
  assign w_addr_ok = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr[31:ADDR_W+2] == '0);
`else
  logic w_unused_addr_bits;
  assign w_addr_ok          = 1'b1;
  assign w_unused_addr_bits = ^{w_sel_addr[31:ADDR_W+2], w_sel_addr[1:0]};
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_fetch_gnt      = 1'b0;
    w_ld_gnt         = 1'b0;
    w_next_state     = S_IDLE;
    w_next_burst_cnt = r_burst_cnt;
    // Loader wins ties until it has taken MAX_LD_BURST slots in a row from a waiting fetch.
    if (bus.ld_req && (!bus.fetch_req || (r_burst_cnt < BURST_MAX))) begin
      w_ld_gnt     = 1'b1;
      w_next_state = S_LOAD;
    end else if (bus.fetch_req) begin
      w_fetch_gnt  = 1'b1;
      w_next_state = S_FETCH;
    end
    if (!bus.fetch_req || w_fetch_gnt) begin
      w_next_burst_cnt = '0;
    end else if (w_ld_gnt && (r_burst_cnt < BURST_MAX)) begin
      w_next_burst_cnt = r_burst_cnt + 1'b1;
    end
    if (reset) begin
      w_fetch_gnt      = 1'b0;
      w_ld_gnt         = 1'b0;
      w_next_state     = S_IDLE;
      w_next_burst_cnt = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_ld_wr     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_burst_cnt <= w_next_burst_cnt;
      r_ld_wr     <= w_ld_gnt & bus.ld_we;
      r_err       <= w_accept & ~w_addr_ok;
    end
  end

  // The registered owner of the previous accept decides which response port fires.
  always_comb begin
    w_resp_owner = R_NONE;
    if (!r_err) begin
      case (r_state)
        S_FETCH: w_resp_owner = R_FETCH;
        S_LOAD:  w_resp_owner = r_ld_wr ? R_LOAD_WR : R_LOAD_RD;
        default: w_resp_owner = R_NONE;
      endcase
    end
  end

  assign bus.fetch_gnt   = w_fetch_gnt;
  assign bus.ld_gnt      = w_ld_gnt;
  assign bus.cpu_stall   = bus.fetch_req & ~w_fetch_gnt & ~reset;

  assign bus.mem_en      = w_accept & w_addr_ok;
  assign bus.mem_we      = bus.mem_en & w_ld_gnt & bus.ld_we;
  assign bus.mem_addr    = bus.mem_en ? w_sel_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata   = bus.mem_we ? bus.ld_wdata : '0;

  assign bus.fetch_valid = (w_resp_owner == R_FETCH);
  assign bus.fetch_data  = (w_resp_owner == R_FETCH) ? bus.mem_rdata : '0;
  assign bus.ld_valid    = (w_resp_owner == R_LOAD_RD) || (w_resp_owner == R_LOAD_WR);
  assign bus.ld_rdata    = (w_resp_owner == R_LOAD_RD) ? bus.mem_rdata : '0;

`ifdef IMEM_ADDR_CHECK_EN
  assign bus.fetch_err   = r_err & (r_state == S_FETCH);
  assign bus.ld_err      = r_err & (r_state == S_LOAD);
`endif
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed self-checking bench for imem_access_arbiter with a write-first RAM model.
// Vector table for steady-state behaviour plus hand sequences for reset and address corner cases.
module tb_imem_access_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  imem_access_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  imem_access_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LD_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata     <= mem[bus.mem_addr];
      end
    end
  end

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lr;
    logic        lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        e_fg;
    logic        e_lg;
    logic        e_stall;
    logic        e_men;
    logic        e_mwe;
    logic [9:0]  e_maddr;
    logic [31:0] e_mwd;
    logic        e_fv;
    logic [31:0] e_fd;
    logic        e_lv;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                     input logic [31:0] la, input logic [31:0] lwd,
                     input logic fg, input logic lg, input logic st, input logic men,
                     input logic mwe, input logic [9:0] maddr, input logic [31:0] mwd,
                     input logic fv, input logic [31:0] fd, input logic lv, input logic [31:0] ld);
    vec_t v;
    v = '{fr, fa, lr, lwe, la, lwd, fg, lg, st, men, mwe, maddr, mwd, fv, fd, lv, ld};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd);
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.ld_req     = lr;
    bus.ld_we      = lwe;
    bus.ld_addr    = la;
    bus.ld_wdata   = lwd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch_gnt"},   bus.fetch_gnt,   0);
    check({tag, "_ld_gnt"},      bus.ld_gnt,      0);
    check({tag, "_cpu_stall"},   bus.cpu_stall,   0);
    check({tag, "_mem_en"},      bus.mem_en,      0);
    check({tag, "_mem_we"},      bus.mem_we,      0);
    check({tag, "_mem_addr"},    bus.mem_addr,    0);
    check({tag, "_mem_wdata"},   bus.mem_wdata,   0);
    check({tag, "_fetch_valid"}, bus.fetch_valid, 0);
    check({tag, "_fetch_data"},  bus.fetch_data,  0);
    check({tag, "_ld_valid"},    bus.ld_valid,    0);
    check({tag, "_ld_rdata"},    bus.ld_rdata,    0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    mem[1]        = 32'hE3A0_0001;
    bus.mem_rdata = '0;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #3;
    check_all_zero("reset");
    #10 reset = 1'b0;

    //  fr fa       lr we la       lwd           fg lg st men we addr wdata         fv fd            lv ld
    add(0, 0,       0, 0, 0,       0,            0, 0, 0, 0,  0, 0,   0,            0, 0,            0, 0);
    add(1, 'h0,     0, 0, 0,       0,            1, 0, 0, 1,  0, 0,   0,            0, 0,            0, 0);
    add(1, 'h4,     0, 0, 0,       0,            1, 0, 0, 1,  0, 1,   0,            1, 'hA000_0000,  0, 0);
    add(1, 'h8,     0, 0, 0,       0,            1, 0, 0, 1,  0, 2,   0,            1, 'hE3A0_0001,  0, 0);
    add(0, 0,       1, 1, 'h10,    'h1234_5678,  0, 1, 0, 1,  1, 4,   'h1234_5678,  1, 'hA000_0002,  0, 0);
    add(1, 'h10,    0, 0, 0,       0,            1, 0, 0, 1,  0, 4,   0,            0, 0,            1, 0);
    add(0, 0,       1, 0, 'h10,    0,            0, 1, 0, 1,  0, 4,   0,            1, 'h1234_5678,  0, 0);
    add(0, 0,       0, 0, 0,       0,            0, 0, 0, 0,  0, 0,   0,            0, 0,            1, 'h1234_5678);
    add(0, 0,       0, 0, 0,       0,            0, 0, 0, 0,  0, 0,   0,            0, 0,            0, 0);
    // Both requesters held for 10 cycles: L,L,L,L,F,L,L,L,L,F
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            0, 0);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            1, 0, 0, 1,  0, 1,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            1, 'hE3A0_0001,  0, 0);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            0, 1, 1, 1,  0, 3,   0,            0, 0,            1, 'hA000_0003);
    add(1, 'h4,     1, 0, 'hC,     0,            1, 0, 0, 1,  0, 1,   0,            0, 0,            1, 'hA000_0003);
    add(0, 0,       0, 0, 0,       0,            0, 0, 0, 0,  0, 0,   0,            1, 'hE3A0_0001,  0, 0);
    // Loader write then read-back of the same word on consecutive cycles
    add(0, 0,       1, 1, 'h20,    'hCAFE_F00D,  0, 1, 0, 1,  1, 8,   'hCAFE_F00D,  0, 0,            0, 0);
    add(0, 0,       1, 0, 'h20,    0,            0, 1, 0, 1,  0, 8,   0,            0, 0,            1, 0);
    add(0, 0,       0, 0, 0,       0,            0, 0, 0, 0,  0, 0,   0,            0, 0,            1, 'hCAFE_F00D);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lwe, vecs[i].la, vecs[i].lwd);
      @(negedge clk);
      check($sformatf("v%0d_fetch_gnt", i),   bus.fetch_gnt,   vecs[i].e_fg);
      check($sformatf("v%0d_ld_gnt", i),      bus.ld_gnt,      vecs[i].e_lg);
      check($sformatf("v%0d_cpu_stall", i),   bus.cpu_stall,   vecs[i].e_stall);
      check($sformatf("v%0d_mem_en", i),      bus.mem_en,      vecs[i].e_men);
      check($sformatf("v%0d_mem_we", i),      bus.mem_we,      vecs[i].e_mwe);
      check($sformatf("v%0d_mem_addr", i),    bus.mem_addr,    vecs[i].e_maddr);
      check($sformatf("v%0d_mem_wdata", i),   bus.mem_wdata,   vecs[i].e_mwd);
      check($sformatf("v%0d_fetch_valid", i), bus.fetch_valid, vecs[i].e_fv);
      check($sformatf("v%0d_fetch_data", i),  bus.fetch_data,  vecs[i].e_fd);
      check($sformatf("v%0d_ld_valid", i),    bus.ld_valid,    vecs[i].e_lv);
      check($sformatf("v%0d_ld_rdata", i),    bus.ld_rdata,    vecs[i].e_ld);
    end

    // Saturate the burst counter, then reset mid-cycle: outputs drop at once, counter clears.
    @(posedge clk); #1;
    drive(1, 'h0, 1, 0, 'h0, 0);
    repeat (4) @(posedge clk);
    #2;
    check("burst_sat_fetch_gnt", bus.fetch_gnt, 1);
    #1 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("post_reset_ld_gnt",    bus.ld_gnt,    1);
    check("post_reset_fetch_gnt", bus.fetch_gnt, 0);
    check("post_reset_stall",     bus.cpu_stall, 1);
    check("post_reset_ld_valid",  bus.ld_valid,  0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);

    // In-flight fetch response is discarded by a reset pulse.
    @(posedge clk); #1;
    drive(1, 'h8, 0, 0, 0, 0);
    @(negedge clk);
    check("flight_fetch_gnt", bus.fetch_gnt, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    check("flight_valid_before_reset", bus.fetch_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("flight_valid_in_reset", bus.fetch_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("flight_valid_after_%0d", i), bus.fetch_valid, 0);
    end

    // Misaligned and aliased addresses.
    @(posedge clk); #1;
    drive(1, 'h6, 0, 0, 0, 0);
    @(negedge clk);
    check("fetch6_gnt", bus.fetch_gnt, 1);
`ifdef IMEM_ADDR_CHECK_EN
    check("fetch6_mem_en", bus.mem_en, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 'h1000, 0);
    @(negedge clk);
    check("fetch6_err",    bus.fetch_err,   1);
    check("fetch6_valid",  bus.fetch_valid, 0);
    check("fetch6_data",   bus.fetch_data,  0);
    check("ld1000_gnt",    bus.ld_gnt,      1);
    check("ld1000_mem_en", bus.mem_en,      0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("fetch6_err_pulse_end", bus.fetch_err, 0);
    check("ld1000_err",           bus.ld_err,    1);
    check("ld1000_valid",         bus.ld_valid,  0);
    @(posedge clk); #1;
    check("ld1000_err_pulse_end", bus.ld_err, 0);
`else
    check("fetch6_mem_en",   bus.mem_en,   1);
    check("fetch6_mem_addr", bus.mem_addr, 1);
    @(posedge clk); #1;
    drive(1, 'h1004, 0, 0, 0, 0);
    @(negedge clk);
    check("fetch6_valid",      bus.fetch_valid, 1);
    check("fetch6_data",       bus.fetch_data,  'hE3A0_0001);
    check("fetch1004_mem_addr", bus.mem_addr,   1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("fetch1004_data", bus.fetch_data, 'hE3A0_0001);
`endif

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
